// File: rtl/mem_pkg.sv
// Shared encodings, sizes and state type for the memory-stage access controller.
package mem_pkg;

    // Access size encodings on i_bhw; 2'b10 decodes as a word access.
    localparam logic [1:0] BHW_BYTE     = 2'b00;
    localparam logic [1:0] BHW_HALFWORD = 2'b01;
    localparam logic [1:0] BHW_WORD     = 2'b11;

    localparam int unsigned BYTE_SZ     = 8;
    localparam int unsigned HALFWORD_SZ = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoadWait,
        StRmwMerge
    } state_e;

    // Any size with bhw[1] set is a full-word access.
    function automatic logic is_word(input logic [1:0] bhw);
        return bhw[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] bhw, input logic [1:0] offset);
        if (is_word(bhw)) begin
            return offset != 2'b00;
        end else if (bhw == BHW_HALFWORD) begin
            return offset[0];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/lane_unit.sv
// Byte/halfword lane handling: extract-and-extend for loads, lane merge for stores.
module lane_unit
    import mem_pkg::*;
#(
    parameter int unsigned B = 32
) (
    input  logic                   merge_i,
    input  logic [B-1:0]           word_i,
    input  logic [HALFWORD_SZ-1:0] data_i,
    input  logic [1:0]             offset_i,
    input  logic [1:0]             bhw_i,
    input  logic                   unsigned_i,
    output logic [B-1:0]           result_o
);

    logic [4:0]             byte_sh;
    logic [4:0]             half_sh;
    logic [B-1:0]           byte_shifted;
    logic [B-1:0]           half_shifted;
    logic [BYTE_SZ-1:0]     byte_lane;
    logic [HALFWORD_SZ-1:0] half_lane;
    logic [B-1:0]           byte_mask;
    logic [B-1:0]           half_mask;
    logic [B-1:0]           byte_ins;
    logic [B-1:0]           half_ins;
    logic                   byte_sign;
    logic                   half_sign;

    // Lane select, sign/zero extension and lane replacement.
    always_comb begin
        byte_sh      = {offset_i, 3'b000};
        half_sh      = {offset_i[1], 4'b0000};
        byte_shifted = word_i >> byte_sh;
        half_shifted = word_i >> half_sh;
        byte_lane    = byte_shifted[BYTE_SZ-1:0];
        half_lane    = half_shifted[HALFWORD_SZ-1:0];
        byte_sign    = byte_lane[BYTE_SZ-1] & ~unsigned_i;
        half_sign    = half_lane[HALFWORD_SZ-1] & ~unsigned_i;
        byte_mask    = {{(B-BYTE_SZ){1'b0}}, {BYTE_SZ{1'b1}}} << byte_sh;
        half_mask    = {{(B-HALFWORD_SZ){1'b0}}, {HALFWORD_SZ{1'b1}}} << half_sh;
        byte_ins     = {{(B-BYTE_SZ){1'b0}}, data_i[BYTE_SZ-1:0]} << byte_sh;
        half_ins     = {{(B-HALFWORD_SZ){1'b0}}, data_i} << half_sh;
        result_o     = word_i;
        if (merge_i) begin
            case (bhw_i)
                BHW_BYTE:     result_o = (word_i & ~byte_mask) | byte_ins;
                BHW_HALFWORD: result_o = (word_i & ~half_mask) | half_ins;
                default:      result_o = word_i;
            endcase
        end else begin
            case (bhw_i)
                BHW_BYTE:     result_o = {{(B-BYTE_SZ){byte_sign}}, byte_lane};
                BHW_HALFWORD: result_o = {{(B-HALFWORD_SZ){half_sign}}, half_lane};
                default:      result_o = word_i;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: word-aligned loads/stores, sub-word stores via read-modify-write.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned B = 32,
    parameter int unsigned W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_valid,
    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [1:0]   i_bhw,
    input  logic         i_unsigned,
    input  logic [W-1:0] i_addr,
    input  logic [B-1:0] i_wdata,
    output logic         o_stall,
    output logic         o_load_valid,
    output logic [B-1:0] o_load_data,
    output logic         o_misaligned,
    output logic         o_dm_read,
    output logic         o_dm_write,
    output logic [W-1:0] o_dm_addr,
    output logic [B-1:0] o_dm_wdata,
    input  logic [B-1:0] i_dm_rdata
);

    state_e                 state_q, state_d;
    logic [1:0]             off_q;
    logic [1:0]             bhw_q;
    logic                   uns_q;
    logic [HALFWORD_SZ-1:0] wdata_q;
    logic                   capture;
    logic                   req;
    logic [W-1:0]           aligned_addr;
    logic [B-1:0]           lane_result;

    assign req          = i_valid & (i_mem_read | i_mem_write);
    assign aligned_addr = {i_addr[W-1:2], 2'b00};

    lane_unit #(
        .B (B)
    ) u_lane_unit (
        .merge_i    (state_q == StRmwMerge),
        .word_i     (i_dm_rdata),
        .data_i     (wdata_q),
        .offset_i   (off_q),
        .bhw_i      (bhw_q),
        .unsigned_i (uns_q),
        .result_o   (lane_result)
    );

    // Mealy outputs and next state; everything reads 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        o_stall      = 1'b0;
        o_load_valid = 1'b0;
        o_load_data  = '0;
        o_misaligned = 1'b0;
        o_dm_read    = 1'b0;
        o_dm_write   = 1'b0;
        o_dm_addr    = '0;
        o_dm_wdata   = '0;
        if (i_reset_n) begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        if (is_misaligned(i_bhw, i_addr[1:0])) begin
                            o_misaligned = 1'b1;
                        end else if (i_mem_write && is_word(i_bhw)) begin
                            o_dm_write = 1'b1;
                            o_dm_addr  = aligned_addr;
                            o_dm_wdata = i_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            o_dm_read = 1'b1;
                            o_dm_addr = aligned_addr;
                            o_stall   = 1'b1;
                            capture   = 1'b1;
                            state_d   = i_mem_write ? StRmwMerge : StLoadWait;
                        end
                    end
                end
                StLoadWait: begin
                    o_load_valid = 1'b1;
                    o_load_data  = lane_result;
                    state_d      = StIdle;
                end
                StRmwMerge: begin
                    // EX/MEM held the request, so i_addr still names the target word.
                    o_dm_write = 1'b1;
                    o_dm_addr  = aligned_addr;
                    o_dm_wdata = lane_result;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register and per-access capture of offset, size, signedness and store data.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            off_q   <= '0;
            bhw_q   <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                off_q   <= i_addr[1:0];
                bhw_q   <= i_bhw;
                uns_q   <= i_unsigned;
                wdata_q <= i_wdata[HALFWORD_SZ-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read word memory model.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  bhw;
    logic        uns;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        dm_read;
    logic        dm_write;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [8];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .B (32),
        .W (5)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_valid      (valid),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_bhw        (bhw),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_load_valid (load_valid),
        .o_load_data  (load_data),
        .o_misaligned (misaligned),
        .o_dm_read    (dm_read),
        .o_dm_write   (dm_write),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: write port and registered read port.
    always @(posedge clk) begin
        if (dm_write) mem[dm_addr[4:2]] <= dm_wdata;
        if (dm_read) dm_rdata <= mem[dm_addr[4:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request, follow it through its stall cycles, then drop i_valid.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic u, input logic [4:0] a, input logic [31:0] d,
                         output int stalls, output logic lv, output logic [31:0] ld,
                         output logic mis, output logic strobe0);
        @(negedge clk);
        valid = 1'b1; mem_read = rd; mem_write = wr; bhw = size; uns = u; addr = a; wdata = d;
        stalls = 0; lv = 1'b0; ld = '0;
        #1;
        mis     = misaligned;
        strobe0 = dm_read | dm_write;
        for (int c = 0; c < 8; c++) begin
            if (load_valid) begin
                lv = 1'b1;
                ld = load_data;
            end
            if (!stall) break;
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 8) check("stall_timeout", 32'(stalls), 32'd1);
        @(negedge clk);
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    int          st;
    logic        lv;
    logic [31:0] ld;
    logic        mis;
    logic        strb;

    initial begin
        reset_n = 1'b0; valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        bhw = 2'b11; uns = 1'b0; addr = 5'h04; wdata = '0;

        // Reset held for two cycles with a request on the inputs.
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dm_read", 32'(dm_read), 32'd0);
        check("rst_dm_write", 32'(dm_write), 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        valid = 1'b0; mem_read = 1'b0;
        reset_n = 1'b1;

        // SW then LW at 0x04.
        issue(0, 1, 2'b11, 0, 5'h04, 32'hDEADBEEF, st, lv, ld, mis, strb);
        check("sw_stalls", 32'(st), 32'd0);
        check("sw_mem", mem[1], 32'hDEADBEEF);
        issue(1, 0, 2'b11, 0, 5'h04, 32'h0, st, lv, ld, mis, strb);
        check("lw_stalls", 32'(st), 32'd1);
        check("lw_valid", 32'(lv), 32'd1);
        check("lw_data", ld, 32'hDEADBEEF);

        // SB 0x80 @0x05 into 0x11223344, then LB/LBU.
        issue(0, 1, 2'b11, 0, 5'h04, 32'h11223344, st, lv, ld, mis, strb);
        issue(0, 1, 2'b00, 0, 5'h05, 32'hFFFFFF80, st, lv, ld, mis, strb);
        check("sb_stalls", 32'(st), 32'd1);
        check("sb_no_load", 32'(lv), 32'd0);
        check("sb_mem", mem[1], 32'h11228044);
        issue(1, 0, 2'b00, 0, 5'h05, 32'h0, st, lv, ld, mis, strb);
        check("lb_data", ld, 32'hFFFFFF80);
        issue(1, 0, 2'b00, 1, 5'h05, 32'h0, st, lv, ld, mis, strb);
        check("lbu_data", ld, 32'h00000080);

        // SH 0xBEEF @0x06 into zero, then LH/LHU and other lanes.
        issue(0, 1, 2'b11, 0, 5'h04, 32'h0, st, lv, ld, mis, strb);
        issue(0, 1, 2'b01, 0, 5'h06, 32'h1234BEEF, st, lv, ld, mis, strb);
        check("sh_stalls", 32'(st), 32'd1);
        check("sh_mem", mem[1], 32'hBEEF0000);
        issue(1, 0, 2'b01, 0, 5'h06, 32'h0, st, lv, ld, mis, strb);
        check("lh_data", ld, 32'hFFFFBEEF);
        issue(1, 0, 2'b01, 1, 5'h06, 32'h0, st, lv, ld, mis, strb);
        check("lhu_data", ld, 32'h0000BEEF);
        issue(1, 0, 2'b00, 0, 5'h07, 32'h0, st, lv, ld, mis, strb);
        check("lb_lane3", ld, 32'hFFFFFFBE);
        issue(1, 0, 2'b01, 0, 5'h04, 32'h0, st, lv, ld, mis, strb);
        check("lh_lane0", ld, 32'h00000000);

        // Read and write together behave as a store.
        issue(1, 1, 2'b00, 0, 5'h04, 32'h00000012, st, lv, ld, mis, strb);
        check("rw_no_load", 32'(lv), 32'd0);
        check("rw_mem", mem[1], 32'hBEEF0012);

        // Misaligned LW @0x02 and SH @0x03 leave memory alone.
        issue(0, 1, 2'b11, 0, 5'h00, 32'h55AA55AA, st, lv, ld, mis, strb);
        issue(1, 0, 2'b11, 0, 5'h02, 32'h0, st, lv, ld, mis, strb);
        check("mis_lw_flag", 32'(mis), 32'd1);
        check("mis_lw_strobe", 32'(strb), 32'd0);
        check("mis_lw_stalls", 32'(st), 32'd0);
        check("mis_lw_no_load", 32'(lv), 32'd0);
        issue(0, 1, 2'b01, 0, 5'h03, 32'h0000FFFF, st, lv, ld, mis, strb);
        check("mis_sh_flag", 32'(mis), 32'd1);
        check("mis_sh_strobe", 32'(strb), 32'd0);
        check("mis_sh_stalls", 32'(st), 32'd0);
        check("mis_mem", mem[0], 32'h55AA55AA);

        // Reset during RMW_MERGE aborts the write.
        issue(0, 1, 2'b11, 0, 5'h08, 32'hCAFEBABE, st, lv, ld, mis, strb);
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; bhw = 2'b00; addr = 5'h09;
        wdata = 32'h000000AA;
        #1;
        check("abort_first_read", 32'(dm_read), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_no_write", 32'(dm_write), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; valid = 1'b0; mem_write = 1'b0;
        #1;
        check("abort_idle_write", 32'(dm_write), 32'd0);
        @(negedge clk);
        check("abort_mem", mem[2], 32'hCAFEBABE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
